// File: rtl/data_mem_responder_if.sv
// Load/store bus between the memory stage (master) and the data-memory
// responder (slave).
//   req_*  : request from the memory stage, qualified by req_valid/req_ready
//   resp_* : single-cycle response, resp_rdata/resp_error qualified by resp_valid
//   stall  : pipeline hold while a request is in flight
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        stall;

  modport master (
    output req_valid, req_addr, req_wdata, req_load, req_store, req_size, req_unsigned,
    input  req_ready, resp_valid, resp_rdata, resp_error, stall
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_load, req_store, req_size, req_unsigned,
    output req_ready, resp_valid, resp_rdata, resp_error, stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts LATENCY
// wait states, performs byte/half/word access on an internal word array and
// returns a one-cycle response.
//   clk    : clock, all state changes on rising edge
//   rst_n  : asynchronous active-low reset (array contents are kept)
//   bus_if : slave side of the load/store bus (request, response, stall)
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  data_mem_responder_if.slave bus_if
);

  localparam int unsigned IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
  localparam bit          ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        uns_q, load_q, store_q;

  logic [31:0] resp_rdata_q;
  logic        resp_error_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp, err, we;
  logic [31:0] op_addr, op_wdata, off, rd_word, sh_word, ld_data, st_data;
  logic [1:0]  op_size;
  logic        op_uns, op_ld, op_st;
  logic [3:0]  be;
  logic [IW-1:0] idx;

  assign accept = bus_if.req_valid && bus_if.req_ready &&
                  (bus_if.req_load || bus_if.req_store);

  // With zero latency the array access happens on the accept edge itself,
  // so the live request is used instead of the latched copy.
  always_comb begin
    if (ZERO_LAT) begin
      op_addr  = bus_if.req_addr;
      op_wdata = bus_if.req_wdata;
      op_size  = bus_if.req_size;
      op_uns   = bus_if.req_unsigned;
      op_ld    = bus_if.req_load;
      op_st    = bus_if.req_store;
    end else begin
      op_addr  = addr_q;
      op_wdata = wdata_q;
      op_size  = size_q;
      op_uns   = uns_q;
      op_ld    = load_q;
      op_st    = store_q;
    end
  end

  assign enter_resp = ZERO_LAT ? accept : (state_q == WAIT && cnt_q == '0);

  // Request decode: range check is unsigned, so addresses below BASE_ADDR wrap.
  always_comb begin
    off = op_addr - BASE_ADDR;
    idx = off[IW+1:2];
    err = (op_ld && op_st) || (op_size == 2'd3) ||
          (op_size == 2'd1 && op_addr[0]) ||
          (op_size == 2'd2 && op_addr[1:0] != 2'b00) ||
          ({1'b0, off} >= LIMIT);
    case (op_size)
      2'd0:    begin be = 4'b0001 << op_addr[1:0];           st_data = {4{op_wdata[7:0]}};  end
      2'd1:    begin be = op_addr[1] ? 4'b1100 : 4'b0011;    st_data = {2{op_wdata[15:0]}}; end
      default: begin be = 4'b1111;                           st_data = op_wdata;            end
    endcase
    rd_word = mem[idx];
    sh_word = rd_word >> {op_addr[1:0], 3'b000};
    case (op_size)
      2'd0:    ld_data = op_uns ? {24'h0, sh_word[7:0]}  : {{24{sh_word[7]}}, sh_word[7:0]};
      2'd1:    ld_data = op_uns ? {16'h0, sh_word[15:0]} : {{16{sh_word[15]}}, sh_word[15:0]};
      default: ld_data = rd_word;
    endcase
    we = enter_resp && op_st && !err && rst_n;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        if (accept) begin
          if (ZERO_LAT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus_if.req_ready  = (state_q == IDLE) || (state_q == RESP);
    bus_if.resp_valid = (state_q == RESP);
    bus_if.stall      = (state_q == WAIT) || accept;
    bus_if.resp_rdata = resp_rdata_q;
    bus_if.resp_error = resp_error_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus_if.req_addr;
      wdata_q <= bus_if.req_wdata;
      size_q  <= bus_if.req_size;
      uns_q   <= bus_if.req_unsigned;
      load_q  <= bus_if.req_load;
      store_q <= bus_if.req_store;
    end
  end

  // Response data is only non-zero during the RESP cycle it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else if (enter_resp) begin
      resp_rdata_q <= (op_ld && !err) ? ld_data : '0;
      resp_error_q <= err;
    end else begin
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if ifa ();
  data_mem_responder_if ifb ();

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus_if(ifa.slave));

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0), .BASE_ADDR(32'h0000_0100)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus_if(ifb.slave));

  typedef struct {
    bit          sel;   // 0: LATENCY=2 instance, 1: LATENCY=0 instance
    bit          ld;
    bit          st;
    bit [1:0]    size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input bit sel, input bit ld, input bit st, input bit [1:0] size,
                     input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit err, input logic [31:0] rdata);
    vec_t v;
    v.sel = sel; v.ld = ld; v.st = st; v.size = size; v.uns = uns;
    v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit sel, input bit valid, input vec_t v);
    if (!sel) begin
      ifa.req_valid = valid; ifa.req_load = v.ld; ifa.req_store = v.st; ifa.req_size = v.size;
      ifa.req_unsigned = v.uns; ifa.req_addr = v.addr; ifa.req_wdata = v.wdata;
    end else begin
      ifb.req_valid = valid; ifb.req_load = v.ld; ifb.req_store = v.st; ifb.req_size = v.size;
      ifb.req_unsigned = v.uns; ifb.req_addr = v.addr; ifb.req_wdata = v.wdata;
    end
  endtask

  function automatic logic [2:0] ctl(input bit sel);  // {req_ready, stall, resp_valid}
    return sel ? {ifb.req_ready, ifb.stall, ifb.resp_valid}
               : {ifa.req_ready, ifa.stall, ifa.resp_valid};
  endfunction

  function automatic logic [32:0] resp(input bit sel);  // {resp_error, resp_rdata}
    return sel ? {ifb.resp_error, ifb.resp_rdata} : {ifa.resp_error, ifa.resp_rdata};
  endfunction

  // One request from IDLE: accept cycle, lat WAIT cycles, one RESP cycle, then idle.
  task automatic xact(input string nm, input vec_t v);
    int lat = v.sel ? 0 : 2;
    logic [32:0] r;
    @(negedge clk); drive(v.sel, 1'b1, v); #1;
    chk({nm, " accept ctl"}, 32'(ctl(v.sel)), 32'b110);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk); drive(v.sel, 1'b0, v); #1;
      chk({nm, " wait ctl"}, 32'(ctl(v.sel)), 32'b010);
    end
    @(negedge clk); drive(v.sel, 1'b0, v); #1;
    chk({nm, " resp ctl"}, 32'(ctl(v.sel)), 32'b101);
    r = resp(v.sel);
    chk({nm, " resp_error"}, 32'(r[32]), 32'(v.err));
    chk({nm, " resp_rdata"}, r[31:0], v.rdata);
    @(negedge clk); #1;
    chk({nm, " after ctl"}, 32'(ctl(v.sel)), 32'b100);
    r = resp(v.sel);
    chk({nm, " after rdata"}, r[31:0], 32'h0);
  endtask

  initial begin
    vec_t z, v;
    z = '{default: '0};
    drive(1'b0, 1'b0, z);
    drive(1'b1, 1'b0, z);

    //   sel ld st size uns addr          wdata         err rdata
    add(0, 0, 1, 2, 0, 32'h10,       32'hDEADBEEF, 0, 32'h0);
    add(0, 1, 0, 2, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF);
    add(0, 0, 1, 0, 0, 32'h13,       32'hAAAAAA80, 0, 32'h0);
    add(0, 1, 0, 0, 0, 32'h13,       32'h0,        0, 32'hFFFFFF80);
    add(0, 1, 0, 0, 1, 32'h13,       32'h0,        0, 32'h00000080);
    add(0, 1, 0, 2, 0, 32'h10,       32'h0,        0, 32'h80ADBEEF);
    add(0, 1, 0, 1, 0, 32'h11,       32'h0,        1, 32'h0);
    add(0, 0, 1, 2, 0, 32'h12,       32'h11111111, 1, 32'h0);
    add(0, 0, 1, 3, 0, 32'h10,       32'h22222222, 1, 32'h0);
    add(0, 1, 0, 2, 0, 32'h10,       32'h0,        0, 32'h80ADBEEF);
    add(0, 1, 0, 2, 0, 32'h1000,     32'h0,        1, 32'h0);
    add(0, 1, 0, 2, 0, 32'hFFFFFFFC, 32'h0,        1, 32'h0);
    add(0, 1, 1, 2, 0, 32'h10,       32'h33333333, 1, 32'h0);
    add(0, 1, 0, 2, 0, 32'h10,       32'h0,        0, 32'h80ADBEEF);
    add(0, 0, 1, 0, 0, 32'h11,       32'h0000005A, 0, 32'h0);
    add(0, 1, 0, 2, 0, 32'h10,       32'h0,        0, 32'h80AD5AEF);
    add(0, 1, 0, 1, 0, 32'h10,       32'h0,        0, 32'h00005AEF);
    add(0, 1, 0, 1, 0, 32'h12,       32'h0,        0, 32'hFFFF80AD);
    add(0, 1, 0, 1, 1, 32'h12,       32'h0,        0, 32'h000080AD);
    add(0, 0, 1, 1, 0, 32'h16,       32'h1234CAFE, 0, 32'h0);
    add(0, 1, 0, 1, 0, 32'h16,       32'h0,        0, 32'hFFFFCAFE);
    add(0, 0, 1, 2, 0, 32'hFFC,      32'h01020304, 0, 32'h0);
    add(0, 1, 0, 2, 0, 32'hFFC,      32'h0,        0, 32'h01020304);
    add(0, 0, 1, 2, 0, 32'h20,       32'hAAAA5555, 0, 32'h0);
    add(1, 1, 0, 2, 0, 32'hFC,       32'h0,        1, 32'h0);
    add(1, 1, 0, 2, 0, 32'h140,      32'h0,        1, 32'h0);
    add(1, 0, 1, 2, 0, 32'h13C,      32'h55AA00FF, 0, 32'h0);
    add(1, 1, 0, 2, 0, 32'h13C,      32'h0,        0, 32'h55AA00FF);
    add(1, 1, 0, 0, 0, 32'h13C,      32'h0,        0, 32'hFFFFFFFF);
    add(1, 1, 0, 0, 1, 32'h13D,      32'h0,        0, 32'h00000000);

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("reset ctl a", 32'(ctl(1'b0)), 32'b100);
    chk("reset resp a", 32'(resp(1'b0)), 32'h0);
    chk("reset ctl b", 32'(ctl(1'b1)), 32'b100);
    rst_n = 1'b1;

    // Valid without load or store is ignored
    @(negedge clk);
    v = z; v.size = 2'd2; v.addr = 32'h10;
    drive(1'b0, 1'b1, v); #1;
    chk("nop stall", 32'(ctl(1'b0)), 32'b100);
    @(negedge clk); drive(1'b0, 1'b0, v); #1;
    chk("nop not accepted", 32'(ctl(1'b0)), 32'b100);

    for (int i = 0; i < vecs.size(); i++) xact($sformatf("vec%0d", i), vecs[i]);

    // LATENCY=0 back-to-back: load accepted in the store's RESP cycle
    v = z; v.st = 1'b1; v.size = 2'd2; v.addr = 32'h100; v.wdata = 32'h0BADF00D;
    @(negedge clk); drive(1'b1, 1'b1, v); #1;
    chk("b2b store accept", 32'(ctl(1'b1)), 32'b110);
    v.st = 1'b0; v.ld = 1'b1; v.wdata = 32'h0;
    @(negedge clk); drive(1'b1, 1'b1, v); #1;
    chk("b2b store resp+load accept", 32'(ctl(1'b1)), 32'b111);
    chk("b2b store resp", 32'(resp(1'b1)), 32'h0);
    @(negedge clk); drive(1'b1, 1'b0, v); #1;
    chk("b2b load resp ctl", 32'(ctl(1'b1)), 32'b101);
    chk("b2b load resp", 32'(resp(1'b1)), 32'h0BADF00D);
    @(negedge clk); #1;
    chk("b2b idle", 32'(ctl(1'b1)), 32'b100);

    // Reset during WAIT of a store aborts it
    v = z; v.st = 1'b1; v.size = 2'd2; v.addr = 32'h20; v.wdata = 32'h12345678;
    @(negedge clk); drive(1'b0, 1'b1, v); #1;
    chk("abort accept", 32'(ctl(1'b0)), 32'b110);
    @(negedge clk); drive(1'b0, 1'b0, v); #1;
    chk("abort in wait", 32'(ctl(1'b0)), 32'b010);
    rst_n = 1'b0; #1;
    chk("abort reset ctl", 32'(ctl(1'b0)), 32'b100);
    chk("abort reset resp", 32'(resp(1'b0)), 32'h0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("abort held", 32'(ctl(1'b0)), 32'b100);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("abort no resp", 32'(ctl(1'b0)), 32'b100);
    end
    v = z; v.ld = 1'b1; v.size = 2'd2; v.addr = 32'h20; v.rdata = 32'hAAAA5555;
    xact("abort old data", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder at the far end of the Stage4Mem load/store interface.
- Accepts one request at a time from the memory stage over a valid/ready handshake and inserts LATENCY wait states.
- Performs byte/half/word stores or sign/zero-extended loads on an internal word array.
- Returns a single-cycle response and drives a stall to the pipeline while the request is in flight.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array.
- LATENCY, 2: wait-state cycles between accept and response; 0 is legal.
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept this cycle.
- req_addr  in  32  byte address (ALU result from the memory stage).
- req_wdata  in  32  store data (rs2 value), bits taken from the LSB end.
- req_load  in  1  load request.
- req_store  in  1  store request.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend load result when 1, sign-extend when 0.
- resp_valid  out  1  response valid; one-cycle pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  request was rejected; qualified by resp_valid.
- stall  out  1  hold the pipeline.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, stall=0.
  - Internal: state=IDLE, wait counter=0.
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- Accept: occurs when req_valid && req_ready && (req_load || req_store). On accept, address, data, size, unsigned flag and kind are latched.
  - req_valid with neither load nor store: ignored, not accepted.
- req_ready = (state==IDLE) || (state==RESP).
- Transitions:
  - IDLE/RESP + accept, LATENCY>0: go to WAIT, counter = LATENCY-1.
  - IDLE/RESP + accept, LATENCY=0: go to RESP.
  - WAIT: decrement counter each cycle; go to RESP when counter==0 at the edge.
  - RESP without accept: go to IDLE.
- Latency: resp_valid is high exactly in the cycle LATENCY+1 cycles after the accept edge. Back-to-back accepts therefore give one response per LATENCY+1 cycles.
- stall is combinational: stall = (state==WAIT) || (state!=WAIT && accept). It is low in a RESP cycle with no new accept, so the stage advances with resp_rdata present.
- Error checks (evaluated on latched request):
  - req_load && req_store both set.
  - req_size==3.
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - (addr - BASE_ADDR) >= DEPTH_WORDS*4, unsigned; addresses below BASE_ADDR wrap and so also fail.
- On error: resp_error=1, resp_rdata=0, no array write.
- Store: commits to the array on the edge entering RESP. Lane mask comes from addr[1:0] and size; req_wdata[7:0] or [15:0] is replicated to the selected lane.
- Load: reads the word on the same edge. Selects the lane by addr[1:0] and extends to 32 bits per req_unsigned. resp_rdata is registered and held only during resp_valid, else 0.
- Load after store to the same address, accepted in the store's RESP cycle: sees the new data.
- Reset asserted mid-WAIT: aborts the request; a pending store is not written and no response is issued.

Test Plan:
- LATENCY=2, store word 0xDEADBEEF @0x10 then load word @0x10.
  - Response: resp_valid 3 cycles after each accept, load rdata=0xDEADBEEF.
  - stall high for the accept cycle and 2 WAIT cycles only.
- Store byte 0x80 @0x13, then load signed byte @0x13 -> 0xFFFFFF80.
  - Load unsigned byte @0x13 -> 0x00000080.
  - Load word @0x10 -> 0x80ADBEEF.
- Misaligned half @0x11, word @0x12, and size=3 -> resp_error=1 and rdata=0 each time; word @0x10 unchanged afterwards.
- Address (DEPTH_WORDS*4) and BASE_ADDR-4 -> resp_error=1; load and store both high -> resp_error=1 with no write.
- LATENCY=0 back-to-back:
  - Store @0x0 then load @0x0 accepted in RESP -> resp_valid on consecutive cycles.
  - Load returns the stored value; stall never covers a RESP cycle without an accept.
- Assert rst_n low in WAIT of a store 0x12345678 @0x20 -> outputs return to their reset values, no response is issued; a later load @0x20 returns the old value.
